fetch_redirect_unit: RTL

Instruction-fetch PC controller that consumes the branch/jump decision made in ID and steers the fetch stream. It owns the PC register, handshakes with instruction memory, and applies redirects from the branch unit (beq/bne/jr) and jump logic. It flushes or keeps the wrong-path/delay-slot instruction, and counts taken redirects. It sits between the hazard unit and branch unit on one side and the IF/ID pipeline register and instruction memory on the other.

---
 rtl/fetch_redirect_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC controller: owns the PC, handshakes with instruction memory,
// applies branch/jump redirects, flushes the wrong-path word, counts redirects.
// Ports: clk, reset (async, active-high); Stall, PCSrc/BranchTarget,
// Jump/JumpTarget, IMemReady in; IMemReq, IMemAddr, PCPlus4, IF_Valid,
// IF_ID_Flush, RedirectCount out.
// Option macro DELAY_SLOT_EN: the word in IF when a redirect is accepted
// is delivered as an architectural delay slot and IF_ID_Flush is tied low.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             PCSrc,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             IMemReady,
  output logic             IMemReq,
  output logic [31:0]      IMemAddr,
  output logic [31:0]      PCPlus4,
  output logic             IF_Valid,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    PENDING
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic [31:0] pend_nxt;
  logic        redirect;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  assign redirect = (PCSrc | Jump) & ~Stall;
  assign target   = Jump ? JumpTarget : BranchTarget;
  // a redirect arriving while already waiting replaces the stored target
  assign pend_nxt = redirect ? target : pend_pc;
  assign IMemAddr = pc;
  assign PCPlus4  = pc + 32'd4;

  always_comb begin
    IMemReq = 1'b0;
    unique case (state)
      FETCH:   IMemReq = ~Stall;
      PENDING: IMemReq = 1'b1;
      default: IMemReq = 1'b0;
    endcase
  end

  always_comb begin
    IF_Valid = 1'b0;
    unique case (state)
`ifdef DELAY_SLOT_EN
      FETCH:   IF_Valid = ~Stall & IMemReady;
      PENDING: IF_Valid = IMemReady;
`else
      FETCH:   IF_Valid = ~Stall & ~redirect & IMemReady;
      PENDING: IF_Valid = 1'b0;
`endif
      default: IF_Valid = 1'b0;
    endcase
  end

`ifdef DELAY_SLOT_EN
  assign IF_ID_Flush = 1'b0;
`else
  assign IF_ID_Flush = redirect & ~reset;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      pend_pc       <= 32'd0;
      RedirectCount <= '0;
    end else begin
      if (redirect && (RedirectCount != '1))
        RedirectCount <= RedirectCount + CNT_ONE;
      unique case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (!Stall) begin
            if (redirect) begin
              if (IMemReady) begin
                pc <= target;
              end else begin
                pend_pc <= target;
                state   <= PENDING;
              end
            end else if (IMemReady) begin
              pc <= PCPlus4;
            end
          end
        end
        PENDING: begin
          if (IMemReady) begin
            pc    <= pend_nxt;
            state <= FETCH;
          end else begin
            pend_pc <= pend_nxt;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
